// File: rtl/biriscv_div_wb_ctrl.sv
// Divider result tracking and writeback control: records the pending rd, stalls decode, holds the result for the writeback arbiter.
// Optional issue-to-result watchdog enabled by defining BIRISCV_DIV_WB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no divide outstanding
// BUSY  | divide in flight, result will be written back
// DRAIN | divide killed by flush, waiting to discard its result
// HOLD  | result captured, waiting for writeback grant
module biriscv_div_wb_ctrl #(
    parameter int TIMEOUT_CYCLES = 40
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        issue_valid_i,
    input  logic [4:0]  issue_rd_idx_i,
    input  logic [31:0] issue_pc_i,
    input  logic        flush_i,
    input  logic [4:0]  dec_ra_idx_i,
    input  logic [4:0]  dec_rb_idx_i,
    input  logic [4:0]  dec_rd_idx_i,
    input  logic        div_valid_i,
    input  logic [31:0] div_value_i,
    input  logic        wb_ready_i,
    output logic        div_busy_o,
    output logic        hazard_o,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_idx_o,
    output logic [31:0] wb_value_o,
    output logic [31:0] wb_pc_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [4:0]  rd_q;
    logic [31:0] pc_q;
    logic [31:0] value_q;
    logic        capture_issue;
    logic        capture_value;
    logic        timeout_hit;

    always_comb begin
        state_d       = state_q;
        capture_issue = 1'b0;
        capture_value = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (issue_valid_i) begin
                    if (flush_i) begin
                        state_d = ST_DRAIN;
                    end else begin
                        capture_issue = 1'b1;
                        state_d       = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (div_valid_i) begin
                    if (!flush_i) begin
                        capture_value = 1'b1;
                        state_d       = (rd_q != 5'd0) ? ST_HOLD : ST_IDLE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (flush_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (div_valid_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (wb_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A stuck divider abandons the operation; nothing is written back.
        if (timeout_hit) begin
            state_d       = ST_IDLE;
            capture_value = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            rd_q    <= 5'd0;
            pc_q    <= 32'd0;
            value_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (capture_issue) begin
                rd_q <= issue_rd_idx_i;
                pc_q <= issue_pc_i;
            end
            if (capture_value) begin
                value_q <= div_value_i;
            end
        end
    end

`ifdef BIRISCV_DIV_WB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q;
    logic       timeout_q;
    logic       counting;
    logic       entering;

    assign counting    = (state_q == ST_BUSY) || (state_q == ST_DRAIN);
    assign entering    = ((state_d == ST_BUSY) || (state_d == ST_DRAIN)) && (state_d != state_q);
    assign timeout_hit = counting && !div_valid_i && (cnt_q == TIMEOUT_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            if (timeout_hit) begin
                timeout_q <= 1'b1;
            end
            if (entering) begin
                cnt_q <= 8'd0;
            end else if (counting) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_hit = 1'b0;
    // The watchdog limit has no effect without the counter.
    assign timeout_o   = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

    assign div_busy_o  = (state_q != ST_IDLE);
    assign wb_valid_o  = (state_q == ST_HOLD);
    assign wb_rd_idx_o = rd_q;
    assign wb_value_o  = value_q;
    assign wb_pc_o     = pc_q;

    // Destination match on decode rd catches WAW as well as RAW.
    assign hazard_o = ((state_q == ST_BUSY) || (state_q == ST_HOLD)) && (rd_q != 5'd0) &&
                      ((dec_ra_idx_i == rd_q) || (dec_rb_idx_i == rd_q) || (dec_rd_idx_i == rd_q));

endmodule

// File: tb/tb_biriscv_div_wb_ctrl.sv
// Directed bench for biriscv_div_wb_ctrl; the watchdog scenario follows BIRISCV_DIV_WB_TIMEOUT_EN.
module tb_biriscv_div_wb_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        issue_valid_i;
    logic [4:0]  issue_rd_idx_i;
    logic [31:0] issue_pc_i;
    logic        flush_i;
    logic [4:0]  dec_ra_idx_i;
    logic [4:0]  dec_rb_idx_i;
    logic [4:0]  dec_rd_idx_i;
    logic        div_valid_i;
    logic [31:0] div_value_i;
    logic        wb_ready_i;
    logic        div_busy_o;
    logic        hazard_o;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_idx_o;
    logic [31:0] wb_value_o;
    logic [31:0] wb_pc_o;
    logic        timeout_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    biriscv_div_wb_ctrl #(.TIMEOUT_CYCLES(40)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .issue_valid_i  (issue_valid_i),
        .issue_rd_idx_i (issue_rd_idx_i),
        .issue_pc_i     (issue_pc_i),
        .flush_i        (flush_i),
        .dec_ra_idx_i   (dec_ra_idx_i),
        .dec_rb_idx_i   (dec_rb_idx_i),
        .dec_rd_idx_i   (dec_rd_idx_i),
        .div_valid_i    (div_valid_i),
        .div_value_i    (div_value_i),
        .wb_ready_i     (wb_ready_i),
        .div_busy_o     (div_busy_o),
        .hazard_o       (hazard_o),
        .wb_valid_o     (wb_valid_o),
        .wb_rd_idx_o    (wb_rd_idx_o),
        .wb_value_o     (wb_value_o),
        .wb_pc_o        (wb_pc_o),
        .timeout_o      (timeout_o)
    );

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [31:0] pc);
        issue_valid_i  = 1'b1;
        issue_rd_idx_i = rd;
        issue_pc_i     = pc;
        tick();
        issue_valid_i  = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; issue_valid_i = 1'b0; issue_rd_idx_i = 5'd0; issue_pc_i = 32'd0;
        flush_i = 1'b0; dec_ra_idx_i = 5'd1; dec_rb_idx_i = 5'd2; dec_rd_idx_i = 5'd3;
        div_valid_i = 1'b0; div_value_i = 32'd0; wb_ready_i = 1'b1;
        tick(); tick();
        rst_i = 1'b0;
        n_vec++;
        if ({div_busy_o, hazard_o, wb_valid_o, wb_rd_idx_o, wb_value_o, wb_pc_o, timeout_o} !== 73'd0) begin
            n_err++;
            $display("FAIL reset_outputs got busy=%b haz=%b wbv=%b rd=%0d val=%h pc=%h to=%b want all 0",
                     div_busy_o, hazard_o, wb_valid_o, wb_rd_idx_o, wb_value_o, wb_pc_o, timeout_o);
        end
    endtask

    task automatic test_basic();
        int bad = 0;
        issue(5'd5, 32'h100);
        n_vec++;
        if ({div_busy_o, wb_valid_o} !== 2'b10) begin
            n_err++; $display("FAIL basic_busy got busy=%b wbv=%b want 1 0", div_busy_o, wb_valid_o);
        end
        repeat (33) begin
            tick();
            if ({div_busy_o, wb_valid_o} !== 2'b10) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++; $display("FAIL basic_wait got %0d bad cycles want 0", bad);
        end
        div_valid_i = 1'b1; div_value_i = 32'h7;
        tick();
        div_valid_i = 1'b0; div_value_i = 32'h0;
        n_vec++;
        if (wb_valid_o !== 1'b1) begin
            n_err++; $display("FAIL basic_wbv got %b want 1", wb_valid_o);
        end
        n_vec++;
        if ({wb_rd_idx_o, wb_value_o, wb_pc_o} !== {5'd5, 32'h7, 32'h100}) begin
            n_err++; $display("FAIL basic_data got rd=%0d val=%h pc=%h want 5 7 100", wb_rd_idx_o, wb_value_o, wb_pc_o);
        end
        tick();
        n_vec++;
        if ({div_busy_o, wb_valid_o} !== 2'b00) begin
            n_err++; $display("FAIL basic_idle got busy=%b wbv=%b want 0 0", div_busy_o, wb_valid_o);
        end
    endtask

    task automatic test_rd_zero();
        int bad = 0;
        dec_ra_idx_i = 5'd0; dec_rb_idx_i = 5'd0; dec_rd_idx_i = 5'd0;
        issue(5'd0, 32'h180);
        #1;
        n_vec++;
        if ({div_busy_o, hazard_o} !== 2'b10) begin
            n_err++; $display("FAIL rd0_hazard got busy=%b haz=%b want 1 0", div_busy_o, hazard_o);
        end
        repeat (3) begin
            tick();
            if (wb_valid_o !== 1'b0) bad++;
        end
        div_valid_i = 1'b1; div_value_i = 32'hFFFF_FFFF;
        tick();
        div_valid_i = 1'b0;
        if (wb_valid_o !== 1'b0) bad++;
        n_vec++;
        if ({div_busy_o, bad} !== {1'b0, 32'd0}) begin
            n_err++; $display("FAIL rd0_discard got busy=%b bad=%0d want 0 0", div_busy_o, bad);
        end
        tick();
        n_vec++;
        if (wb_valid_o !== 1'b0) begin
            n_err++; $display("FAIL rd0_after got wbv=%b want 0", wb_valid_o);
        end
        dec_ra_idx_i = 5'd1; dec_rb_idx_i = 5'd2; dec_rd_idx_i = 5'd3;
    endtask

    task automatic test_flush();
        issue(5'd3, 32'h200);
        repeat (9) tick();
        flush_i = 1'b1;
        tick();
        n_vec++;
        if ({div_busy_o, wb_valid_o, hazard_o} !== 3'b100) begin
            n_err++; $display("FAIL flush_drain got busy=%b wbv=%b haz=%b want 1 0 0", div_busy_o, wb_valid_o, hazard_o);
        end
        tick();
        flush_i = 1'b0;
        n_vec++;
        if (div_busy_o !== 1'b1) begin
            n_err++; $display("FAIL flush_in_drain got busy=%b want 1", div_busy_o);
        end
        div_valid_i = 1'b1; div_value_i = 32'h1234;
        tick();
        div_valid_i = 1'b0;
        n_vec++;
        if ({div_busy_o, wb_valid_o} !== 2'b00) begin
            n_err++; $display("FAIL flush_discard got busy=%b wbv=%b want 0 0", div_busy_o, wb_valid_o);
        end
        issue(5'd3, 32'h210);
        tick();
        flush_i = 1'b1; div_valid_i = 1'b1; div_value_i = 32'h1234;
        tick();
        flush_i = 1'b0; div_valid_i = 1'b0;
        n_vec++;
        if ({div_busy_o, wb_valid_o} !== 2'b00) begin
            n_err++; $display("FAIL flush_coincident got busy=%b wbv=%b want 0 0", div_busy_o, wb_valid_o);
        end
        flush_i = 1'b1;
        issue(5'd3, 32'h220);
        flush_i = 1'b0;
        n_vec++;
        if (div_busy_o !== 1'b1) begin
            n_err++; $display("FAIL flush_at_issue got busy=%b want 1", div_busy_o);
        end
        div_valid_i = 1'b1;
        tick();
        div_valid_i = 1'b0;
        n_vec++;
        if ({div_busy_o, wb_valid_o} !== 2'b00) begin
            n_err++; $display("FAIL flush_at_issue_end got busy=%b wbv=%b want 0 0", div_busy_o, wb_valid_o);
        end
    endtask

    task automatic test_hazard();
        dec_ra_idx_i = 5'd1; dec_rb_idx_i = 5'd2; dec_rd_idx_i = 5'd3;
        issue(5'd8, 32'h400);
        dec_ra_idx_i = 5'd8;
        #1;
        n_vec++;
        if (hazard_o !== 1'b1) begin
            n_err++; $display("FAIL hazard_ra got %b want 1", hazard_o);
        end
        dec_ra_idx_i = 5'd2; dec_rb_idx_i = 5'd9; dec_rd_idx_i = 5'd8;
        #1;
        n_vec++;
        if (hazard_o !== 1'b1) begin
            n_err++; $display("FAIL hazard_waw got %b want 1", hazard_o);
        end
        dec_ra_idx_i = 5'd1; dec_rb_idx_i = 5'd2; dec_rd_idx_i = 5'd3;
        #1;
        n_vec++;
        if (hazard_o !== 1'b0) begin
            n_err++; $display("FAIL hazard_none got %b want 0", hazard_o);
        end
        dec_rb_idx_i = 5'd8;
        #1;
        n_vec++;
        if (hazard_o !== 1'b1) begin
            n_err++; $display("FAIL hazard_rb got %b want 1", hazard_o);
        end
        dec_rb_idx_i = 5'd2; dec_ra_idx_i = 5'd8;
        wb_ready_i = 1'b0; div_valid_i = 1'b1; div_value_i = 32'hCAFE_0008;
        tick();
        div_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if ({wb_valid_o, hazard_o, wb_rd_idx_o, wb_value_o, wb_pc_o} !==
                {1'b1, 1'b1, 5'd8, 32'hCAFE_0008, 32'h400}) begin
                n_err++;
                $display("FAIL hold_%0d got wbv=%b haz=%b rd=%0d val=%h pc=%h want 1 1 8 cafe0008 400",
                         i, wb_valid_o, hazard_o, wb_rd_idx_o, wb_value_o, wb_pc_o);
            end
            // Flush and an illegal issue in HOLD must both be ignored.
            if (i == 1) begin
                flush_i = 1'b1; issue_valid_i = 1'b1; issue_rd_idx_i = 5'd9; issue_pc_i = 32'h999;
            end else begin
                flush_i = 1'b0; issue_valid_i = 1'b0;
            end
            tick();
        end
        wb_ready_i = 1'b1;
        tick();
        n_vec++;
        if ({div_busy_o, wb_valid_o, hazard_o} !== 3'b000) begin
            n_err++; $display("FAIL hazard_idle got busy=%b wbv=%b haz=%b want 0 0 0", div_busy_o, wb_valid_o, hazard_o);
        end
        dec_ra_idx_i = 5'd1;
    endtask

    task automatic test_back_to_back();
        issue(5'd10, 32'h500);
        wb_ready_i = 1'b0; div_valid_i = 1'b1; div_value_i = 32'h11;
        tick();
        div_valid_i = 1'b0;
        wb_ready_i = 1'b1; issue_valid_i = 1'b1; issue_rd_idx_i = 5'd11; issue_pc_i = 32'h600;
        tick();
        n_vec++;
        if ({div_busy_o, wb_valid_o} !== 2'b00) begin
            n_err++; $display("FAIL b2b_same_cycle got busy=%b wbv=%b want 0 0", div_busy_o, wb_valid_o);
        end
        tick();
        issue_valid_i = 1'b0;
        n_vec++;
        if (div_busy_o !== 1'b1) begin
            n_err++; $display("FAIL b2b_next_cycle got busy=%b want 1", div_busy_o);
        end
        div_valid_i = 1'b1; div_value_i = 32'h22;
        tick();
        div_valid_i = 1'b0;
        n_vec++;
        if ({wb_valid_o, wb_rd_idx_o, wb_value_o, wb_pc_o} !== {1'b1, 5'd11, 32'h22, 32'h600}) begin
            n_err++; $display("FAIL b2b_data got wbv=%b rd=%0d val=%h pc=%h want 1 11 22 600",
                              wb_valid_o, wb_rd_idx_o, wb_value_o, wb_pc_o);
        end
        tick();
    endtask

    task automatic test_reset_busy();
        issue(5'd6, 32'h300);
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        n_vec++;
        if ({div_busy_o, hazard_o, wb_valid_o, wb_rd_idx_o, wb_value_o, wb_pc_o, timeout_o} !== 73'd0) begin
            n_err++; $display("FAIL rst_busy got busy=%b wbv=%b rd=%0d val=%h pc=%h want all 0",
                              div_busy_o, wb_valid_o, wb_rd_idx_o, wb_value_o, wb_pc_o);
        end
        div_valid_i = 1'b1; div_value_i = 32'h55;
        tick();
        div_valid_i = 1'b0;
        n_vec++;
        if ({div_busy_o, wb_valid_o, wb_value_o} !== 34'd0) begin
            n_err++; $display("FAIL rst_pulse_ignored got busy=%b wbv=%b val=%h want 0 0 0", div_busy_o, wb_valid_o, wb_value_o);
        end
    endtask

    task automatic test_timeout();
`ifdef BIRISCV_DIV_WB_TIMEOUT_EN
        int bad = 0;
        issue(5'd4, 32'h700);
        repeat (39) tick();
        n_vec++;
        if ({div_busy_o, timeout_o} !== 2'b10) begin
            n_err++; $display("FAIL timeout_early got busy=%b to=%b want 1 0", div_busy_o, timeout_o);
        end
        tick();
        n_vec++;
        if ({div_busy_o, wb_valid_o, timeout_o} !== 3'b001) begin
            n_err++; $display("FAIL timeout_fire got busy=%b wbv=%b to=%b want 0 0 1", div_busy_o, wb_valid_o, timeout_o);
        end
        repeat (5) begin
            tick();
            if (timeout_o !== 1'b1) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++; $display("FAIL timeout_sticky got %0d cleared cycles want 0", bad);
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        n_vec++;
        if (timeout_o !== 1'b0) begin
            n_err++; $display("FAIL timeout_reset got %b want 0", timeout_o);
        end
`else
        issue(5'd4, 32'h700);
        repeat (45) tick();
        n_vec++;
        if ({div_busy_o, timeout_o} !== 2'b10) begin
            n_err++; $display("FAIL no_watchdog got busy=%b to=%b want 1 0", div_busy_o, timeout_o);
        end
        div_valid_i = 1'b1; div_value_i = 32'h4;
        tick();
        div_valid_i = 1'b0;
        n_vec++;
        if ({wb_valid_o, wb_rd_idx_o, wb_value_o} !== {1'b1, 5'd4, 32'h4}) begin
            n_err++; $display("FAIL late_result got wbv=%b rd=%0d val=%h want 1 4 4", wb_valid_o, wb_rd_idx_o, wb_value_o);
        end
        tick();
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rd_zero();
        test_flush();
        test_hazard();
        test_back_to_back();
        test_reset_busy();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/biriscv_div_wb_ctrl.md
Name: biriscv_div_wb_ctrl

Overview:
Tracking and writeback stage directly downstream of the integer divider. It records the destination register of each issued DIV/DIVU/REM/REMU and stalls decode while the divide is outstanding. It captures the divider's one-cycle result pulse, holds it, and presents it to the shared register-file writeback arbiter. It also squashes results of divides killed by a pipeline flush.

Parameters:
TIMEOUT_CYCLES, 40, watchdog limit in cycles from issue to divider result (used only with the optional feature)

Ports:
clk_i  in  1  core clock
rst_i  in  1  reset; synchronous, active-high
issue_valid_i  in  1  divide instruction issued to divider this cycle
issue_rd_idx_i  in  5  destination register of issued divide
issue_pc_i  in  32  PC of issued divide
flush_i  in  1  pipeline flush; kills an in-flight divide
dec_ra_idx_i  in  5  rs1 index of instruction in decode
dec_rb_idx_i  in  5  rs2 index of instruction in decode
dec_rd_idx_i  in  5  rd index of instruction in decode
div_valid_i  in  1  divider result strobe (single-cycle pulse)
div_value_i  in  32  divider result
wb_ready_i  in  1  writeback arbiter grant for this port
div_busy_o  out  1  divider unit occupied; no new divide may issue
hazard_o  out  1  decode instruction depends on pending divide rd
wb_valid_o  out  1  result waiting for writeback
wb_rd_idx_o  out  5  writeback destination
wb_value_o  out  32  writeback data
wb_pc_o  out  32  PC of the divide being written back
timeout_o  out  1  watchdog error (optional feature only; else tied 0)

Behaviour:
- States: IDLE, BUSY, DRAIN, HOLD. All transitions occur on the rising edge of clk_i.
- Reset (rst_i sampled high): state=IDLE. All outputs are 0. rd, pc and value registers are cleared. Reset during any state aborts it without writeback.
- IDLE:
  - issue_valid_i & !flush_i -> capture rd and pc; go to BUSY.
  - issue_valid_i & flush_i -> go to DRAIN. The divider has already started and its result must be discarded.
  - div_valid_i in IDLE is ignored.
- BUSY:
  - div_valid_i & !flush_i -> capture div_value_i. If rd!=0, go to HOLD. If rd==0, discard and go to IDLE.
  - flush_i & !div_valid_i -> go to DRAIN.
  - flush_i & div_valid_i in the same cycle -> discard the result; go to IDLE.
- DRAIN: div_valid_i -> go to IDLE, no writeback. flush_i is ignored.
- HOLD: wb_valid_o=1. wb_ready_i=1 -> go to IDLE this edge. flush_i is ignored, because the result is already committed.
- wb_valid_o = (state==HOLD).
  - wb_rd_idx_o, wb_value_o and wb_pc_o are registered and stable for the whole of HOLD.
  - Minimum latency from div_valid_i to wb_valid_o is 1 cycle.
- div_busy_o = (state!=IDLE). issue_valid_i while div_busy_o=1 is a protocol violation; it is ignored and the state is unchanged.
- hazard_o is combinational. It equals (state==BUSY or HOLD) & rd!=0 & (dec_ra_idx_i==rd | dec_rb_idx_i==rd | dec_rd_idx_i==rd). The last term covers WAW.
- hazard_o=0 in DRAIN and IDLE.
- Back-to-back: a new issue is accepted in the cycle after the HOLD->IDLE transition, never in the same cycle as it.

Optional Feature:
Macro BIRISCV_DIV_WB_TIMEOUT_EN.
- Defined:
  - An 8-bit cycle counter clears on entry to BUSY or DRAIN and increments each cycle in those states.
  - When it reaches TIMEOUT_CYCLES without div_valid_i, timeout_o is asserted as a sticky flag and the state is forced to IDLE with no writeback.
  - timeout_o is cleared only by rst_i.
- Not defined: no counter is built and timeout_o is tied to 0.

Test Plan:
1. Issue rd=5, pc=0x100. Hold div_valid_i low for 34 cycles, then pulse it with value 0x7.
   -> div_busy_o=1 from the cycle after issue.
   -> wb_valid_o=1 one cycle after the pulse, with rd 5, value 0x7, pc 0x100.
   -> With wb_ready_i=1, idle the next cycle.
2. Issue rd=0, then pulse div_valid_i with 0xFFFFFFFF. -> wb_valid_o never asserts; returns to IDLE the cycle after the pulse.
3. Issue rd=3, assert flush_i 10 cycles later, then pulse div_valid_i with 0x1234. -> DRAIN; no writeback. Variant with flush_i coincident with the pulse: no writeback, IDLE.
4. Issue rd=8 with decode ra=8, then ra=2/rb=9/rd=8, then ra=1/rb=2/rd=3. -> hazard_o=1, 1, 0. Also hazard_o=1 in HOLD while wb_ready_i is held low for 5 cycles; data stays stable.
5. Assert rst_i in BUSY, then pulse div_valid_i. -> All outputs 0 after reset; the pulse is ignored.
6. With BIRISCV_DIV_WB_TIMEOUT_EN defined and TIMEOUT_CYCLES=40, issue and never pulse div_valid_i. -> timeout_o=1 after 40 cycles, state IDLE, div_busy_o=0, timeout_o remains 1 until rst_i.
